// File: rtl/mac_pkg.sv
// Shared types and operand/product widths for the dot-product MAC slice.
package mac_pkg;
  localparam int OP_W   = 4;
  localparam int PROD_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/mac_acc_add.sv
// Accumulator adder; saturates at all-ones and flags the carry when MAC_SAT_EN is defined.
module mac_acc_add
  import mac_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] add_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              ovf_o
);
  logic [ACC_W-1:0] add_ext;
  assign add_ext = ACC_W'(add_i);

`ifdef MAC_SAT_EN
  logic [ACC_W:0] wide;
  assign wide  = {1'b0, acc_i} + {1'b0, add_ext};
  assign ovf_o = wide[ACC_W];
  assign sum_o = ovf_o ? '1 : wide[ACC_W-1:0];
`else
  assign sum_o = acc_i + add_ext;
  assign ovf_o = 1'b0;
`endif
endmodule

// File: rtl/mac_array_mult.sv
// 4x4 combinational array multiplier: one shifted partial-product row per multiplier bit.
module mac_array_mult
  import mac_pkg::*;
(
  input  logic [OP_W-1:0]   a_i,
  input  logic [OP_W-1:0]   b_i,
  output logic [PROD_W-1:0] prod_o
);
  logic [OP_W:0][PROD_W-1:0] part;

  assign part[0] = '0;
  for (genvar i = 0; i < OP_W; i++) begin : g_row
    assign part[i+1] = part[i] + (b_i[i] ? (PROD_W'(a_i) << i) : '0);
  end
  assign prod_o = part[OP_W];
endmodule

// File: rtl/dot_product_mac.sv
// Multiply-accumulate controller feeding an external array multiplier.
// Optional saturation + sticky overflow flag under MAC_SAT_EN.
module dot_product_mac
  import mac_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int LEN_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  input  logic [PROD_W-1:0] mul_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              acc_ovf,
  output logic              busy
);
  state_t             state_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W:0]     cnt_q;
  logic               pipe_vld_q;
  logic [OP_W-1:0]    mul_a_q, mul_b_q;
  logic [ACC_W-1:0]   acc_q;
  logic               ovf_q;
  logic               in_ready_q, out_valid_q, busy_q;
  logic [ACC_W-1:0]   sum_d;
  logic               ovf_d;
  logic               accept;
  logic               last_pair;

  assign accept    = (state_q == RUN) && in_valid && in_ready_q;
  assign last_pair = (cnt_q == {1'b0, len_q});

  mac_acc_add #(.ACC_W(ACC_W)) u_add (
    .acc_i (acc_q),
    .add_i (mul_prod),
    .sum_o (sum_d),
    .ovf_o (ovf_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      pipe_vld_q  <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      pipe_vld_q <= accept;
      if (accept) begin
        mul_a_q <= in_a;
        mul_b_q <= in_b;
      end
      // Product of the pair registered last edge lands in the accumulator now.
      if (pipe_vld_q) begin
        acc_q <= sum_d;
        ovf_q <= ovf_q | ovf_d;
      end
      case (state_q)
        IDLE: if (start) begin
          state_q    <= RUN;
          len_q      <= len;
          cnt_q      <= '0;
          acc_q      <= '0;
          ovf_q      <= 1'b0;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b1;
        end
        RUN: if (accept) begin
          cnt_q <= cnt_q + (LEN_W+1)'(1);
          if (last_pair) begin
            state_q    <= DRAIN;
            in_ready_q <= 1'b0;
          end
        end
        DRAIN: if (pipe_vld_q) begin
          state_q     <= DONE;
          out_valid_q <= 1'b1;
        end
        DONE: if (out_ready) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign out_valid = out_valid_q;
  assign out_acc   = acc_q;
  assign acc_ovf   = ovf_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_dot_product_mac.sv
// Scoreboard bench for dot_product_mac with a real array multiplier in the loop.
module tb_dot_product_mac;
  import mac_pkg::*;
  localparam int ACC_W = 8;
  localparam int LEN_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  len = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [OP_W-1:0]   in_a = '0, in_b = '0;
  logic [OP_W-1:0]   mul_a, mul_b;
  logic [PROD_W-1:0] mul_prod;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ACC_W-1:0]  out_acc;
  logic              acc_ovf;
  logic              busy;

  always #5 clk = ~clk;

  dot_product_mac #(.ACC_W(ACC_W), .LEN_W(LEN_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_prod(mul_prod),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .acc_ovf(acc_ovf), .busy(busy)
  );

  mac_array_mult u_mult (.a_i(mul_a), .b_i(mul_b), .prod_o(mul_prod));

  typedef struct { logic [ACC_W-1:0] acc; logic ovf; } exp_t;
  exp_t sb[$];
  int   n_chk = 0, n_err = 0;
  int   m_acc = 0;
  logic m_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic madd(input int p);
    int full, mx;
    full = m_acc + p;
    mx   = (1 << ACC_W) - 1;
`ifdef MAC_SAT_EN
    if (full > mx) begin m_acc = mx; m_ovf = 1'b1; end
    else m_acc = full;
`else
    m_acc = full & mx;
`endif
  endtask

  task automatic push_exp();
    exp_t e;
    e.acc = ACC_W'(m_acc);
    e.ovf = m_ovf;
    sb.push_back(e);
  endtask

  task automatic begin_job(input int l);
    start = 1'b1; len = LEN_W'(l);
    tick();
    start = 1'b0; m_acc = 0; m_ovf = 1'b0;
    chk("busy_run", busy, 1);
  endtask

  task automatic send(input int a, input int b);
    int n = 0;
    in_a = OP_W'(a); in_b = OP_W'(b); in_valid = 1'b1;
    while (!in_ready && n < 20) begin tick(); n++; end
    chk("rdy_wait", in_ready, 1);
    tick();
    in_valid = 1'b0;
    madd(a * b);
  endtask

  task automatic collect(input int hold);
    int n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    chk("done_wait", out_valid, 1);
    repeat (hold) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_after", busy, 0);
  endtask

  // Pops on every output handshake and checks the result is held while stalled.
  logic             hold_v = 1'b0;
  logic [ACC_W-1:0] hold_val = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) hold_v = 1'b0;
    else if (out_valid) begin
      if (hold_v) chk("hold", out_acc, hold_val);
      if (out_ready) begin
        if (sb.size() == 0) chk("sb_unexp", 1, 0);
        else begin
          e = sb.pop_front();
          chk("acc", out_acc, e.acc);
          chk("ovf", acc_ovf, e.ovf);
        end
        hold_v = 1'b0;
      end else begin
        hold_v = 1'b1; hold_val = out_acc;
      end
    end else hold_v = 1'b0;
  end

  initial begin
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_oval", out_valid, 0);
    chk("rst_rdy", in_ready, 0);
    chk("rst_acc", out_acc, 0);
    rst_n = 1'b1;
    tick();

    // 1: single pair, exact latency
    start = 1'b1; len = '0; in_a = 4'd15; in_b = 4'd15;
    tick();
    start = 1'b0; m_acc = 0; m_ovf = 1'b0;
    chk("t1_rdy", in_ready, 1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0; madd(225);
    chk("t1_rdy_lo", in_ready, 0);
    chk("t1_mula", mul_a, 15);
    chk("t1_oval_e2", out_valid, 0);
    tick();
    chk("t1_oval_e3", out_valid, 1);
    push_exp();
    collect(0);

    // 2: back-to-back pairs
    begin_job(3);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_a = OP_W'(2*i + 1); in_b = OP_W'(2*i + 2);
      chk("t2_rdy", in_ready, 1);
      tick();
      madd((2*i + 1) * (2*i + 2));
    end
    in_valid = 1'b0;
    chk("t2_rdy_lo", in_ready, 0);
    chk("t2_model", m_acc, 100);
    push_exp();
    collect(0);

    // 3: bubbles, stray starts, held result
    begin_job(2);
    start = 1'b1; tick(); start = 1'b0; tick();
    send(2, 3);
    start = 1'b1; tick(); start = 1'b0;
    send(4, 5);
    tick();
    send(6, 7);
    chk("t3_busy", busy, 1);
    push_exp();
    collect(5);

    // 4: 16 x (15,15) overflows an 8-bit accumulator
    begin_job(15);
    for (int i = 0; i < 16; i++) send(15, 15);
    push_exp();
    collect(1);

    // 5: reset mid-job
    begin_job(3);
    send(5, 5);
    send(6, 6);
    rst_n = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_oval", out_valid, 0);
    chk("t5_rdy", in_ready, 0);
    chk("t5_acc", out_acc, 0);
    chk("t5_mula", mul_a, 0);
    chk("t5_mulb", mul_b, 0);
    chk("t5_ovf", acc_ovf, 0);
    tick();
    rst_n = 1'b1;
    tick();
    begin_job(1);
    send(3, 7);
    send(9, 2);
    push_exp();
    collect(0);

    // 6: handshake and start on the same edge
    begin_job(0);
    send(3, 3);
    push_exp();
    while (!out_valid) tick();
    out_ready = 1'b1; start = 1'b1; len = LEN_W'(1);
    tick();
    out_ready = 1'b0;
    chk("t6_idle", busy, 0);
    chk("t6_oval", out_valid, 0);
    tick();
    start = 1'b0; m_acc = 0; m_ovf = 1'b0;
    chk("t6_run", busy, 1);
    chk("t6_clr", out_acc, 0);
    send(2, 2);
    send(1, 3);
    push_exp();
    collect(0);

    repeat (3) tick();
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end
endmodule
